// File: rtl/psram_pkg.sv
// Shared state encoding and bus-width helpers for the PSRAM write-data path.
package psram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_DONE
    } tx_state_t;

    localparam int WORD_W      = 32;
    localparam int DQ_W_NARROW = 4;
    localparam int DQ_W_WIDE   = 8;

    function automatic int beats_of(input int dq_w);
        return WORD_W / dq_w;
    endfunction

    function automatic bit dq_w_legal(input int dq_w);
        return (dq_w == DQ_W_NARROW) || (dq_w == DQ_W_WIDE);
    endfunction

endpackage

// File: rtl/psram_tx_word_fetch.sv
// Word-hand-off side of the buffer interface: arming, availability, free pulse.
import psram_pkg::*;

module psram_tx_word_fetch (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_vld,
    input  logic i_load,
    output logic o_avail,
    output logic o_free
);

    logic r_armed;
    logic r_free;

    // tx_vld lingers after tx_free, so a word only counts once vld has dropped
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_armed <= 1'b0;
            r_free  <= 1'b0;
        end else begin
            r_free <= i_load;
            if (!i_vld) begin
                r_armed <= 1'b1;
            end else if (i_load) begin
                r_armed <= 1'b0;
            end
        end
    end

    assign o_avail = i_vld && r_armed;
    assign o_free  = r_free;

endmodule

// File: rtl/psram_tx_ser.sv
// Serialises buffered 32-bit words MSB-first onto the PSRAM DQ bus
// during the data phase of a write burst.
import psram_pkg::*;

module psram_tx_ser #(
    parameter int DQ_W = 8
) (
    input  logic            psram_clk,
    input  logic            psram_rst,
    input  logic            psram_start,
    input  logic            wr_start,
    input  logic [7:0]      wr_len_m1,
    input  logic            tx_vld,
    input  logic [31:0]     tx_data,
    output logic            tx_free,
    output logic [DQ_W-1:0] dq_out,
    output logic            dq_oe,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic            underrun
);

    localparam int BEATS = beats_of(DQ_W);
    localparam int BC_W  = $clog2(BEATS);
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

    if (!dq_w_legal(DQ_W)) begin : g_bad_dq_w
        $error("psram_tx_ser: DQ_W must be 4 or 8");
    end

    tx_state_t       r_state;
    logic [31:0]     r_shreg;
    logic [BC_W-1:0] r_beat;
    logic [7:0]      r_word;
    logic [7:0]      r_len;
    logic [DQ_W-1:0] r_dq_out;
    logic            r_dq_oe;
    logic            r_busy;
    logic            r_stall;
    logic            r_done;
    logic            r_under;

    logic w_clr;
    logic w_avail;
    logic w_last;
    logic w_more;
    logic w_load;

    assign w_clr  = psram_rst || psram_start;
    assign w_last = (r_state == ST_SEND) && (r_beat == LAST_BEAT);
    assign w_more = (r_word != r_len);
    assign w_load = w_avail &&
                    ((r_state == ST_FETCH) || (w_last && w_more));

    psram_tx_word_fetch u_fetch (
        .i_clk   (psram_clk),
        .i_clr   (w_clr),
        .i_vld   (tx_vld),
        .i_load  (w_load),
        .o_avail (w_avail),
        .o_free  (tx_free)
    );

    // dq_out holds the beat currently on the bus; r_shreg holds the rest
    always_ff @(posedge psram_clk) begin
        if (w_clr) begin
            r_state  <= ST_IDLE;
            r_shreg  <= '0;
            r_beat   <= '0;
            r_word   <= '0;
            r_len    <= '0;
            r_dq_out <= '0;
            r_dq_oe  <= 1'b0;
            r_busy   <= 1'b0;
            r_stall  <= 1'b0;
            r_done   <= 1'b0;
            r_under  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_dq_out <= tx_data[31 -: DQ_W];
                r_shreg  <= tx_data << DQ_W;
                r_beat   <= '0;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (wr_start) begin
                        r_state <= ST_FETCH;
                        r_busy  <= 1'b1;
                        r_word  <= '0;
                        r_len   <= wr_len_m1;
                        r_under <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (w_load) begin
                        r_state <= ST_SEND;
                        r_dq_oe <= 1'b1;
                        r_stall <= 1'b0;
                    end else if (r_word != 8'd0) begin
                        r_stall <= 1'b1;
                        r_under <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (w_last) begin
                        if (!w_more) begin
                            r_state <= ST_DONE;
                            r_dq_oe <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_word <= r_word + 8'd1;
                            if (!w_load) begin
                                r_state <= ST_FETCH;
                                r_dq_oe <= 1'b0;
                                r_stall <= 1'b1;
                                r_under <= 1'b1;
                            end
                        end
                    end else begin
                        r_dq_out <= r_shreg[31 -: DQ_W];
                        r_shreg  <= r_shreg << DQ_W;
                        r_beat   <= r_beat + BC_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dq_out   = r_dq_out;
    assign dq_oe    = r_dq_oe;
    assign busy     = r_busy;
    assign stall    = r_stall;
    assign done     = r_done;
    assign underrun = r_under;

endmodule

// File: tb/tb_psram_tx_ser.sv
// Directed bench for psram_tx_ser at DQ_W=8 and DQ_W=4.
module tb_psram_tx_ser;

    logic        clk = 1'b0;
    logic        psram_rst = 1'b1;
    logic        psram_start = 1'b0;
    logic        wr_start = 1'b0;
    logic [7:0]  wr_len_m1 = '0;
    logic        tx_vld = 1'b0;
    logic [31:0] tx_data = '0;

    logic       free8, oe8, busy8, stall8, done8, und8;
    logic [7:0] dq8;
    logic       free4, oe4, busy4, stall4, done4, und4;
    logic [3:0] dq4;

    int n_tot = 0;
    int n_bad = 0;

    logic [31:0] words [4] = '{32'hA1B2C3D4, 32'h11223344,
                               32'h55667788, 32'h99AABBCC};
    logic [7:0]  exp12 [12] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4,
                                8'h11, 8'h22, 8'h33, 8'h44,
                                8'h55, 8'h66, 8'h77, 8'h88};
    logic [3:0]  expn [8] = '{4'hA, 4'h1, 4'hB, 4'h2,
                              4'hC, 4'h3, 4'hD, 4'h4};

    logic [7:0]  q8[$];
    logic [3:0]  q4[$];
    int          nfree8, ndone8, maxrun, done_cyc, first_oe;
    logic        stall_seen, busy_c1, und_done;
    logic [31:0] dq_done;

    always #5 clk = ~clk;

    psram_tx_ser #(.DQ_W(8)) dut8 (
        .psram_clk   (clk),
        .psram_rst   (psram_rst),
        .psram_start (psram_start),
        .wr_start    (wr_start),
        .wr_len_m1   (wr_len_m1),
        .tx_vld      (tx_vld),
        .tx_data     (tx_data),
        .tx_free     (free8),
        .dq_out      (dq8),
        .dq_oe       (oe8),
        .busy        (busy8),
        .stall       (stall8),
        .done        (done8),
        .underrun    (und8)
    );

    psram_tx_ser #(.DQ_W(4)) dut4 (
        .psram_clk   (clk),
        .psram_rst   (psram_rst),
        .psram_start (psram_start),
        .wr_start    (wr_start),
        .wr_len_m1   (wr_len_m1),
        .tx_vld      (tx_vld),
        .tx_data     (tx_data),
        .tx_free     (free4),
        .dq_out      (dq4),
        .dq_oe       (oe4),
        .busy        (busy4),
        .stall       (stall4),
        .done        (done4),
        .underrun    (und4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // leaves the bench one cycle after reset with tx_vld low, so both DUTs are armed
    task automatic do_reset();
        @(posedge clk); #1;
        psram_rst = 1'b1;
        psram_start = 1'b0;
        wr_start = 1'b0;
        tx_vld = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        psram_rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // buffer model: after tx_free keep vld high `hold` cycles, low `gap`, then next word
    task automatic burst(input logic [7:0] lm1, input int hold, input int gap,
                         input int nw, input int sec_cyc,
                         input logic [7:0] sec_len, input int which);
        int widx, kh, kg, run;
        bit fin;
        logic nv;
        logic [31:0] nd;
        q8.delete();
        q4.delete();
        nfree8 = 0; ndone8 = 0; maxrun = 0; done_cyc = 0; first_oe = 0;
        stall_seen = 0; busy_c1 = 0; und_done = 0; dq_done = '0;
        widx = 0; kh = 0; kg = 0; run = 0; fin = 0;
        nv = 1'b1;
        nd = words[0];
        tx_vld = 1'b1;
        tx_data = words[0];
        wr_len_m1 = lm1;
        wr_start = 1'b1;
        for (int c = 1; c <= 300 && !fin; c++) begin
            @(posedge clk); #1;
            wr_start = (c == sec_cyc);
            if (c == sec_cyc) wr_len_m1 = sec_len;
            tx_vld = nv;
            tx_data = nd;
            @(negedge clk);
            if (c == 1) busy_c1 = busy8;
            if (oe8) begin
                q8.push_back(dq8);
                run++;
                if (run > maxrun) maxrun = run;
                if (first_oe == 0) first_oe = c;
            end else begin
                run = 0;
            end
            if (oe4) q4.push_back(dq4);
            if (free8) begin
                nfree8++;
                widx++;
                kh = hold;
                kg = gap;
            end
            if (stall8) stall_seen = 1'b1;
            if (done8) ndone8++;
            if ((which == 8 && done8) || (which == 4 && done4)) begin
                fin = 1;
                done_cyc = c;
                und_done = (which == 8) ? und8 : und4;
                dq_done = (which == 8) ? {24'b0, dq8} : {28'b0, dq4};
            end
            if (kh > 0) begin
                nv = 1'b1;
                kh--;
            end else if (kg > 0) begin
                nv = 1'b0;
                kg--;
            end else if (widx < nw) begin
                nv = 1'b1;
                nd = words[widx];
            end else begin
                nv = 1'b0;
            end
        end
        chk("burst_finished", 32'(fin), 1);
        wr_start = 1'b0;
    endtask

    task automatic cmp_bytes(input string tag, input int n);
        chk({tag, "_nbeats"}, q8.size(), n);
        for (int i = 0; i < n && i < q8.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), q8[i], exp12[i]);
    endtask

    initial begin
        int nd;
        do_reset();
        @(negedge clk);
        chk("rst_free", free8, 0);
        chk("rst_oe", oe8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_stall", stall8, 0);
        chk("rst_done", done8, 0);
        chk("rst_under", und8, 0);
        chk("rst_dq", dq8, 0);
        @(posedge clk); #1;

        // single word, DQ_W=8
        burst(8'd0, 1000, 0, 1, 0, 8'd0, 8);
        chk("t1_busy_c1", busy_c1, 1);
        chk("t1_first_oe", first_oe, 2);
        cmp_bytes("t1", 4);
        chk("t1_nfree", nfree8, 1);
        chk("t1_done_cyc", done_cyc, 6);
        chk("t1_dq_hold", dq_done, 32'hD4);
        chk("t1_under", und_done, 0);

        // single word, DQ_W=4
        do_reset();
        burst(8'd0, 1000, 0, 1, 0, 8'd0, 4);
        chk("t2_nbeats", q4.size(), 8);
        for (int i = 0; i < 8 && i < q4.size(); i++)
            chk($sformatf("t2_n%0d", i), q4[i], expn[i]);
        chk("t2_done_cyc", done_cyc, 10);

        // slow buffer: vld lingers 6 cycles, low 1, then next word
        do_reset();
        burst(8'd2, 6, 1, 3, 0, 8'd0, 8);
        cmp_bytes("t3", 12);
        chk("t3_nfree", nfree8, 3);
        chk("t3_stall", stall_seen, 1);
        chk("t3_under", und_done, 1);
        chk("t3_done_cyc", done_cyc, 24);
        chk("t3_ndone", ndone8, 1);

        // fast buffer: next word ready before the last beat
        do_reset();
        burst(8'd2, 0, 1, 3, 0, 8'd0, 8);
        cmp_bytes("t4", 12);
        chk("t4_run", maxrun, 12);
        chk("t4_stall", stall_seen, 0);
        chk("t4_under", und_done, 0);
        chk("t4_done_cyc", done_cyc, 14);

        // abort mid-SEND, then a clean burst
        do_reset();
        tx_vld = 1'b1;
        tx_data = words[2];
        wr_len_m1 = 8'd0;
        wr_start = 1'b1;
        @(posedge clk); #1;
        wr_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        psram_start = 1'b1;
        @(negedge clk);
        chk("t5_oe_c3", oe8, 1);
        chk("t5_dq_c3", dq8, 8'h66);
        @(posedge clk); #1;
        psram_start = 1'b0;
        tx_vld = 1'b0;
        @(negedge clk);
        chk("t5_oe_abort", oe8, 0);
        chk("t5_busy_abort", busy8, 0);
        chk("t5_dq_abort", dq8, 0);
        nd = 0;
        repeat (6) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (done8) nd++;
        end
        chk("t5_nodone", nd, 0);
        @(posedge clk); #1;
        burst(8'd0, 1000, 0, 1, 0, 8'd0, 8);
        cmp_bytes("t5", 4);
        chk("t5_done_cyc", done_cyc, 6);
        chk("t5_ndone", ndone8, 1);

        // wr_start while busy must not change the length
        do_reset();
        burst(8'd1, 0, 1, 4, 3, 8'd5, 8);
        cmp_bytes("t6", 8);
        chk("t6_nfree", nfree8, 2);
        chk("t6_done_cyc", done_cyc, 10);
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("t6_idle_busy", busy8, 0);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/psram_tx_ser.md
Name: psram_tx_ser

Overview:
- psram_clk-domain consumer of the write-data buffer's tx_vld/tx_data/tx_free interface.
- Takes one 32-bit word at a time.
- Returns the free pulse and serialises the word MSB-first onto the PSRAM DQ bus, one beat per clock, during the data phase of a write burst.
- The command/address sequencer starts it with a word count; it reports completion, stalls and underruns back.

Parameters:
- DQ_W, 8, DQ bus width in bits; legal values are 4 and 8.
- BEATS, 32/DQ_W, beats per word; derived, not overridable.

Ports:
- psram_clk  in  1  sole clock.
- psram_rst  in  1  synchronous, active-high reset.
- psram_start  in  1  abort/init pulse; same effect as reset on all state.
- wr_start  in  1  pulse; begins a data phase of wr_len_m1+1 words.
- wr_len_m1  in  8  word count minus 1; sampled only on an accepted wr_start.
- tx_vld  in  1  level; a word is present on tx_data.
- tx_data  in  32  word from the buffer; stable while tx_vld=1.
- tx_free  out  1  one-cycle pulse; the word has been consumed.
- dq_out  out  DQ_W  serial data beat.
- dq_oe  out  1  high exactly on cycles that carry a valid beat.
- busy  out  1  high from the cycle after accepted wr_start until done.
- stall  out  1  high while mid-burst and waiting for a word.
- done  out  1  one-cycle pulse after the last beat.
- underrun  out  1  sticky; a mid-burst word was late.

Behaviour:
- Reset (psram_rst or psram_start), in order of priority:
  - state=IDLE; armed=0.
  - tx_free=0, dq_out=0, dq_oe=0, busy=0, stall=0, done=0, underrun=0.
  - All counters are cleared.
- armed register:
  - Set on any cycle with tx_vld=0.
  - Cleared on the load cycle.
  - A word is "available" iff tx_vld && armed. This prevents a double-load, because tx_vld stays high for several cycles after tx_free (cross-domain latency).
- Load: shreg<=tx_data, beat_cnt<=0. tx_free is high on the cycle after the load (registered), for exactly 1 cycle.
- IDLE:
  - wr_start -> FETCH.
  - word_cnt<=0, len<=wr_len_m1, underrun<=0.
  - wr_start in any other state is ignored.
- FETCH:
  - dq_oe=0.
  - If a word is available: load, then go to SEND.
  - stall=1 while word_cnt!=0; underrun is set on the first such cycle.
- SEND, one beat per cycle:
  - dq_out=shreg[31 -: DQ_W], dq_oe=1, shreg shifts left by DQ_W.
  - On beat_cnt==BEATS-1:
    - If word_cnt==len: go to DONE.
    - Else word_cnt++. If a word is available, load it in the same cycle (gapless, next beat follows immediately). Otherwise go to FETCH.
- DONE: done=1 for 1 cycle, busy=0, then IDLE. dq_oe=0.
- Latency:
  - wr_start@c0 -> FETCH@c1.
  - First load at the earliest in c1.
  - First beat (dq_oe=1) at c2.
  - Word count per burst: 1..256.
- dq_out holds its last value when dq_oe=0.
- Simultaneous events:
  - psram_start beats wr_start.
  - A load and armed-set cannot both apply in one cycle, because a load needs tx_vld=1.

Decomposition:
- psram_pkg: state encoding (IDLE/FETCH/SEND/DONE), legal DQ_W values, BEATS function.
- One sub-module, psram_tx_word_fetch: armed flag, available decode and registered tx_free pulse. It is reused by the future read-side return path.

Test Plan:
- DQ_W=8, wr_len_m1=0, tx_data=0xA1B2C3D4 preloaded with tx_vld=1 -> dq_out A1,B2,C3,D4 on 4 consecutive dq_oe cycles starting c2; one tx_free pulse; done pulse at c6.
- DQ_W=4, same word -> nibbles A,1,B,2,C,3,D,4 over 8 beats.
- wr_len_m1=2, tx_vld held high for 6 cycles after tx_free, then low 1 cycle, then high with the next word -> exactly 3 loads; no double-load of a word; stall/underrun asserted during the gap.
- Next word available before the last beat -> 12 consecutive dq_oe beats with no gap; underrun stays 0.
- psram_start mid-SEND -> next cycle dq_oe=0, busy=0, no done pulse; a following wr_start runs a clean burst.
- wr_start while busy -> ignored; len unchanged and the burst completes with the original count.
